// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-side memory responder for the single-cycle RISC-V datapath. A load or
// store request (MemRead/MemWrite, held by the requester until Ready) is
// accepted in IDLE, waits WAIT_CYCLES cycles in BUSY, and is performed on the
// clock edge that enters DONE. DONE lasts exactly one cycle and drives the
// Ready pulse that releases the datapath stall. One word at IO_ADDR is a
// memory-mapped output register (IOOut) with a one-cycle IOValid strobe.
//
// Handshake: the requester raises MemRead and/or MemWrite with Addr/WriteData
// and holds them until it sees Ready=1. Ready is high for exactly one cycle per
// accepted request, ReadData/AddrErr/IOValid are valid only while Ready=1, and
// a request still asserted in the cycle after Ready is a new request.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   MemRead    in   load request
//   MemWrite   in   store request (wins over MemRead)
//   Addr       in   32-bit byte address
//   WriteData  in   32-bit store data
//   ReadData   out  32-bit registered load data (0 for stores and errors)
//   Ready      out  one-cycle completion pulse
//   AddrErr    out  access was misaligned or out of range (valid with Ready)
//   IOOut      out  memory-mapped output register
//   IOValid    out  one-cycle strobe when IOOut is written
//   DbgState   out  current FSM state (0 IDLE, 1 BUSY, 2 DONE) for checkers
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] IO_ADDR     = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AddrErr,
  output logic [31:0] IOOut,
  output logic        IOValid,
  output logic [1:0]  DbgState
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // FSM and datapath registers
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_wr;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_ioout;
  logic          r_iovalid;
  logic [31:0]   r_mem [DEPTH];

  // Combinational signals
  state_t        w_next_state;
  logic [CW-1:0] w_next_cnt;
  logic          w_req;
  logic          w_enter_done;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_data;
  logic          w_acc_wr;
  logic          w_misal;
  logic          w_is_io;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_io_wr;
  logic          w_mem_wr;
  logic [31:0]   w_rd_value;

  assign w_req = MemRead | MemWrite;

  // The access happens on the edge that enters DONE. With WAIT_CYCLES=0 that
  // is the accept edge itself, so the live inputs are used instead of the
  // latched copies (which are only loaded on that same edge).
  assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);
  assign w_acc_addr   = (r_state == S_IDLE) ? Addr      : r_addr;
  assign w_acc_data   = (r_state == S_IDLE) ? WriteData : r_wdata;
  assign w_acc_wr     = (r_state == S_IDLE) ? MemWrite  : r_wr;

  // Address decode: misalignment is checked first, then the IO register,
  // then the storage range; anything else is an address error.
  assign w_misal    = (w_acc_addr[1:0] != 2'b00);
  assign w_is_io    = (w_acc_addr == IO_ADDR);
  assign w_in_range = (w_acc_addr[31:2] < DEPTH_W);
  assign w_idx      = w_acc_addr[AW+1:2];

  assign w_err    = w_misal || (!w_is_io && !w_in_range);
  assign w_io_wr  = w_acc_wr && !w_misal && w_is_io;
  // Reset gates the store so an abandoned or colliding transaction never writes.
  assign w_mem_wr = w_enter_done && !reset && w_acc_wr && !w_misal &&
                    !w_is_io && w_in_range;

  always_comb begin
    w_rd_value = '0;
    if (!w_acc_wr && !w_misal) begin
      if (w_is_io) begin
        w_rd_value = r_ioout;
      end else if (w_in_range) begin
        w_rd_value = r_mem[w_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state register plus registered datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_ioout   <= '0;
      r_iovalid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;

      if ((r_state == S_IDLE) && w_req) begin
        r_addr  <= Addr;
        r_wdata <= WriteData;
        r_wr    <= MemWrite;
      end

      if (w_enter_done) begin
        r_rdata   <= w_rd_value;
        r_err     <= w_err;
        r_iovalid <= w_io_wr;
        if (w_io_wr) begin
          r_ioout <= w_acc_data;
        end
      end else if (r_state == S_DONE) begin
        r_rdata   <= '0;
        r_err     <= 1'b0;
        r_iovalid <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[w_idx] <= w_acc_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state and wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_BUSY;
            w_next_cnt   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        w_next_cnt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs (all driven from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    Ready    = (r_state == S_DONE);
    DbgState = r_state;
    ReadData = r_rdata;
    AddrErr  = r_err;
    IOOut    = r_ioout;
    IOValid  = r_iovalid;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two instances share clock and reset: index 0 uses WAIT_CYCLES=2, index 1
// uses WAIT_CYCLES=0. A transaction-level model tracks edges, accepted
// requests and completion times, storage and IOOut, and predicts every output
// for the cycle after each rising edge. A compare process checks both
// instances on every falling edge; directed sequences add literal checks.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int waits [2] = '{2, 0};

  logic        rd     [2];
  logic        wr     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] o_rdata[2];
  logic        o_rdy  [2];
  logic        o_err  [2];
  logic [31:0] o_io   [2];
  logic        o_iov  [2];
  logic [1:0]  o_dbg  [2];

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .IO_ADDR(32'h0000_0400)) dut_w2 (
    .clk(clk), .reset(reset), .MemRead(rd[0]), .MemWrite(wr[0]),
    .Addr(addr[0]), .WriteData(wdata[0]), .ReadData(o_rdata[0]), .Ready(o_rdy[0]),
    .AddrErr(o_err[0]), .IOOut(o_io[0]), .IOValid(o_iov[0]), .DbgState(o_dbg[0])
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .IO_ADDR(32'h0000_0400)) dut_w0 (
    .clk(clk), .reset(reset), .MemRead(rd[1]), .MemWrite(wr[1]),
    .Addr(addr[1]), .WriteData(wdata[1]), .ReadData(o_rdata[1]), .Ready(o_rdy[1]),
    .AddrErr(o_err[1]), .IOOut(o_io[1]), .IOValid(o_iov[1]), .DbgState(o_dbg[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an accepted request completes WAIT_CYCLES edges after
  // acceptance, Ready shows in the following cycle, and the next request can
  // only be accepted two edges after completion.
  // ---------------------------------------------------------------------------
  bit          m_on = 1'b0;
  longint      edge_n = 0;
  bit          m_pend [2];
  longint      m_done_edge [2];
  longint      m_free_edge [2];
  logic        m_wr   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_mem  [2][256];
  logic        e_rdy  [2];
  logic [31:0] e_rdata[2];
  logic        e_err  [2];
  logic        e_iov  [2];
  logic [31:0] e_io   [2];

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_on           = 1'b1;
        m_pend[i]      = 1'b0;
        m_free_edge[i] = edge_n + 1;
        e_rdy[i]       = 1'b0;
        e_rdata[i]     = '0;
        e_err[i]       = 1'b0;
        e_iov[i]       = 1'b0;
        e_io[i]        = '0;
      end else begin
        e_rdy[i]   = 1'b0;
        e_rdata[i] = '0;
        e_err[i]   = 1'b0;
        e_iov[i]   = 1'b0;
        if (!m_pend[i] && edge_n >= m_free_edge[i] && (rd[i] || wr[i])) begin
          m_pend[i]      = 1'b1;
          m_wr[i]        = wr[i];
          m_addr[i]      = addr[i];
          m_data[i]      = wdata[i];
          m_done_edge[i] = edge_n + waits[i];
        end
        if (m_pend[i] && edge_n == m_done_edge[i]) begin
          m_pend[i]      = 1'b0;
          m_free_edge[i] = edge_n + 2;
          e_rdy[i]       = 1'b1;
          if (m_addr[i] % 4 != 0) begin
            e_err[i] = 1'b1;
          end else if (m_addr[i] == 32'h400) begin
            if (m_wr[i]) begin
              e_io[i]  = m_data[i];
              e_iov[i] = 1'b1;
            end else begin
              e_rdata[i] = e_io[i];
            end
          end else if (m_addr[i] < 32'h400) begin
            if (m_wr[i]) m_mem[i][m_addr[i] / 4] = m_data[i];
            else         e_rdata[i] = m_mem[i][m_addr[i] / 4];
          end else begin
            e_err[i] = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every falling edge once the model has seen reset
  always @(negedge clk) begin
    if (m_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc%0d Ready", i),    32'(o_rdy[i]), 32'(e_rdy[i]));
        chk($sformatf("cyc%0d ReadData", i), o_rdata[i],    e_rdata[i]);
        chk($sformatf("cyc%0d AddrErr", i),  32'(o_err[i]), 32'(e_err[i]));
        chk($sformatf("cyc%0d IOValid", i),  32'(o_iov[i]), 32'(e_iov[i]));
        chk($sformatf("cyc%0d IOOut", i),    o_io[i],       e_io[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: issue one request, hold it until Ready (bounded), then drop it
  // ---------------------------------------------------------------------------
  task automatic access(input int i, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata_o, output logic err_o, output int lat);
    @(negedge clk);
    wr[i] = w; rd[i] = r; addr[i] = a; wdata[i] = d;
    lat = 0; rdata_o = '0; err_o = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_rdy[i]) begin
        lat = k; rdata_o = o_rdata[i]; err_o = o_err[i];
        break;
      end
    end
    wr[i] = 1'b0; rd[i] = 1'b0;
    if (lat == 0) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no Ready for addr 0x%08h on dut %0d", a, i);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] rv;
  logic        ev;
  int          lat;
  int          pulses;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset Ready", 32'(o_rdy[0]), 32'd0);
    chk("reset IOOut", o_io[0], 32'h0);

    // Store then load at address 0
    access(0, 1'b1, 1'b0, 32'h0, 32'h0000_000F, rv, ev, lat);
    chk("st0 latency", 32'(lat), 32'd3);
    chk("st0 AddrErr", 32'(ev), 32'd0);
    chk("st0 ReadData", rv, 32'h0);
    access(0, 1'b0, 1'b1, 32'h0, 32'h0, rv, ev, lat);
    chk("ld0 ReadData", rv, 32'h0000_000F);
    chk("ld0 latency", 32'(lat), 32'd3);
    access(0, 1'b1, 1'b0, 32'h4, 32'h1111_1111, rv, ev, lat);

    // IO register write, one-cycle strobe, read-back
    access(0, 1'b1, 1'b0, 32'h400, 32'h0000_00AB, rv, ev, lat);
    chk("io IOValid high", 32'(o_iov[0]), 32'd1);
    chk("io IOOut", o_io[0], 32'h0000_00AB);
    @(negedge clk);
    chk("io IOValid low", 32'(o_iov[0]), 32'd0);
    chk("io IOOut hold", o_io[0], 32'h0000_00AB);
    access(0, 1'b0, 1'b1, 32'h400, 32'h0, rv, ev, lat);
    chk("io read", rv, 32'h0000_00AB);

    // Address errors
    access(0, 1'b0, 1'b1, 32'h2, 32'h0, rv, ev, lat);
    chk("misal AddrErr", 32'(ev), 32'd1);
    chk("misal ReadData", rv, 32'h0);
    access(0, 1'b1, 1'b0, 32'h800, 32'h1234_5678, rv, ev, lat);
    chk("oor AddrErr", 32'(ev), 32'd1);
    access(0, 1'b0, 1'b1, 32'h0, 32'h0, rv, ev, lat);
    chk("oor mem0 intact", rv, 32'h0000_000F);
    access(0, 1'b0, 1'b1, 32'h800, 32'h0, rv, ev, lat);
    chk("oor read ReadData", rv, 32'h0);

    // Reset while BUSY with a pending store
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b1; wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pulses += int'(o_rdy[0]);
    end
    chk("rst-busy no Ready", 32'(pulses), 32'd0);
    chk("rst-busy IOOut", o_io[0], 32'h0);
    chk("rst-busy ReadData", o_rdata[0], 32'h0);
    access(0, 1'b0, 1'b1, 32'h4, 32'h0, rv, ev, lat);
    chk("rst-busy mem4", rv, 32'h1111_1111);

    // Both request lines high: treated as a store
    access(0, 1'b1, 1'b1, 32'h8, 32'h0000_0055, rv, ev, lat);
    chk("both ReadData", rv, 32'h0);
    chk("both AddrErr", 32'(ev), 32'd0);
    access(0, 1'b0, 1'b1, 32'h8, 32'h0, rv, ev, lat);
    chk("both read-back", rv, 32'h0000_0055);

    // WAIT_CYCLES=0: request held for three back-to-back stores
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 32'hC; wdata[1] = 32'h0000_0077;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pulses += int'(o_rdy[1]);
      chk($sformatf("w0 Ready k=%0d", k), 32'(o_rdy[1]), 32'(k % 2));
    end
    wr[1] = 1'b0;
    chk("w0 pulse count", 32'(pulses), 32'd3);
    access(1, 1'b0, 1'b1, 32'hC, 32'h0, rv, ev, lat);
    chk("w0 read-back", rv, 32'h0000_0077);
    chk("w0 latency", 32'(lat), 32'd1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the single-cycle RISC-V datapath. It accepts the datapath's data-side load/store requests (address, write data, MemWrite, MemRead), services them after a configurable number of wait states, and returns read data with a one-cycle Ready pulse. The datapath uses Ready as its stall release. The block also holds one memory-mapped output register so programs can publish a result word. It sits between the datapath's ALUResult/WriteData/ReadData bus and the word-addressed storage.

## Interface
- DEPTH, 256: number of 32-bit words of storage; legal word index 0..DEPTH-1.
- WAIT_CYCLES, 2: wait states before a response; 0 is legal.
- IO_ADDR, 32'h0000_0400: byte address of the memory-mapped output register.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request; held by the requester until Ready.
- MemWrite  in  1  store request; held until Ready; wins if both asserted.
- Addr  in  32  byte address (datapath ALUResult).
- WriteData  in  32  store data.
- ReadData  out  32  load data; registered, valid while Ready=1.
- Ready  out  1  one-cycle completion pulse.
- AddrErr  out  1  asserted with Ready when the access was misaligned or out of range.
- IOOut  out  32  memory-mapped output register.
- IOValid  out  1  one-cycle pulse when IOOut is written.

## Operation
- The FSM has three states.
  - IDLE: at a clock edge where MemRead|MemWrite=1, latch Addr, WriteData and op (write if MemWrite=1, else read). Go to DONE if WAIT_CYCLES=0, else go to BUSY with cnt=WAIT_CYCLES.
  - BUSY: decrement cnt each edge; at the edge where cnt==1, go to DONE.
  - DONE: Ready=1 for this cycle only; next edge goes to IDLE unconditionally.
- The access is performed at the edge that enters DONE, using the latched values:
  - Addr[1:0]≠0: misaligned. No write; ReadData=0; AddrErr=1.
  - Addr==IO_ADDR: a write loads IOOut and sets IOValid=1 for the DONE cycle; a read returns IOOut.
  - Addr[31:2]<DEPTH: a write stores mem[Addr[31:2]]; a read returns mem[Addr[31:2]].
  - Any other address: AddrErr=1; write dropped; ReadData=0.
- Request inputs are ignored outside IDLE. Changes during BUSY have no effect.
- In the cycle after DONE (IDLE), a still-asserted request is a new request. A new request is accepted at the first IDLE edge. Back-to-back accesses therefore cost WAIT_CYCLES+2 cycles each.
- ReadData is 0 for writes. ReadData, AddrErr and IOValid are updated only at edges entering DONE and are cleared at the edge leaving DONE. IOOut holds its value.
- Reset:
  - Effect: state=IDLE, cnt=0, ReadData=0, Ready=0, AddrErr=0, IOOut=0, IOValid=0. Memory array is not cleared.
  - Reset in BUSY abandons the transaction; the pending write is never performed.
  - Reset in DONE clears Ready at that edge.
  - Reset takes priority over a request at the same edge.

## Timing
- Request accepted at edge N → DONE entered at edge N+WAIT_CYCLES → Ready high during the cycle after edge N+WAIT_CYCLES (WAIT_CYCLES+1 cycles after acceptance).
- With WAIT_CYCLES=0, Ready is high in the cycle directly after the accept edge.
- Memory write and IOOut update become visible at the edge entering DONE. A read accepted at the next IDLE edge returns the new value.
- Ready is exactly one cycle wide and never asserted twice per accepted request.
- No combinational path from inputs to outputs.

## Test plan
- Store then load, WAIT_CYCLES=2:
  - Write 0x0000000F to 0x0000_0000 → Ready 3 cycles after accept, AddrErr=0.
  - Read 0x0 → ReadData=0x0000000F while Ready=1.
- IO write of 0x000000AB to 0x0000_0400 → IOOut=0x000000AB, IOValid=1 for one cycle. A following read of 0x400 returns 0x000000AB.
- Address errors:
  - Read 0x0000_0002 → AddrErr=1, ReadData=0.
  - Write 0x12345678 to 0x0000_0800 → AddrErr=1, and mem[0..255] is unchanged (checked by later reads).
- Reset in BUSY after accepting a write of 0xDEADBEEF to 0x4 → Ready never pulses, all outputs 0. A later read of 0x4 returns the prior content, not 0xDEADBEEF.
- MemRead=MemWrite=1 to 0x8 with data 0x55 → treated as write: ReadData=0, later read of 0x8 returns 0x55.
- WAIT_CYCLES=0, request held continuously for 3 accesses → Ready high every second cycle, 3 pulses in 6 cycles.
